net_tx_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single outbound network AXI-stream (64-bit data, 8-bit keep, 64-bit user) between NUM_SRC application TX streams; for example the memcached header-handler TX output and a control/management responder. It sits between the per-application TX outputs and the MAC-side toNet interface. Once a source is granted, it keeps the grant until its tlast beat is accepted, so packets never interleave.

---
 rtl/net_tx_arb_pkg.sv | 23 ++
 rtl/net_tx_arbiter_if.sv | 47 ++++
 rtl/net_tx_arbiter_rr_pick.sv | 26 ++
 rtl/net_tx_arbiter.sv | 117 +++++++++++
 tb/tb_net_tx_arbiter.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/net_tx_arb_pkg.sv
// Shared constants, FSM encoding and index helper for the network TX arbiter.
// Imported by net_tx_arbiter_if, rr_pick and net_tx_arbiter.
package net_tx_arb_pkg;

    localparam int DATA_W  = 64;
    localparam int KEEP_W  = 8;
    localparam int USER_W  = 64;
    localparam int CNT_W   = 32;
    localparam int GRANT_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } arb_state_e;

    // (base + off) mod n, used for the round-robin pointer and its search order.
    function automatic logic [GRANT_W-1:0] wrap_idx(input logic [GRANT_W-1:0] base,
                                                    input int unsigned        off,
                                                    input int unsigned        n);
        return GRANT_W'((32'(base) + off) % n);
    endfunction

endpackage

// File: rtl/net_tx_arbiter_if.sv
// Bundle of the per-source TX streams, the shared toNet stream and the status outputs.
// slave = arbiter side, master = application/MAC/test side.
interface net_tx_arbiter_if
    import net_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = 2
);
    logic [NUM_SRC*DATA_W-1:0] src_axis_tdata;
    logic [NUM_SRC*KEEP_W-1:0] src_axis_tkeep;
    logic [NUM_SRC*USER_W-1:0] src_axis_tuser;
    logic [NUM_SRC-1:0]        src_axis_tlast;
    logic [NUM_SRC-1:0]        src_axis_tvalid;
    logic [NUM_SRC-1:0]        src_axis_tready;

    logic [DATA_W-1:0]         toNet_axis_tdata;
    logic [KEEP_W-1:0]         toNet_axis_tkeep;
    logic [USER_W-1:0]         toNet_axis_tuser;
    logic                      toNet_axis_tlast;
    logic                      toNet_axis_tvalid;
    logic                      toNet_axis_tready;

    logic [GRANT_W-1:0]        grant_id;
    logic                      busy;
    logic                      stats_clear;
    logic [NUM_SRC*CNT_W-1:0]  pkt_cnt;

    modport slave (
        input  src_axis_tdata, src_axis_tkeep, src_axis_tuser, src_axis_tlast, src_axis_tvalid,
        output src_axis_tready,
        output toNet_axis_tdata, toNet_axis_tkeep, toNet_axis_tuser, toNet_axis_tlast,
        output toNet_axis_tvalid,
        input  toNet_axis_tready,
        output grant_id, busy, pkt_cnt,
        input  stats_clear
    );

    modport master (
        output src_axis_tdata, src_axis_tkeep, src_axis_tuser, src_axis_tlast, src_axis_tvalid,
        input  src_axis_tready,
        input  toNet_axis_tdata, toNet_axis_tkeep, toNet_axis_tuser, toNet_axis_tlast,
        input  toNet_axis_tvalid,
        output toNet_axis_tready,
        input  grant_id, busy, pkt_cnt,
        output stats_clear
    );

endinterface

// File: rtl/net_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping.
module rr_pick
    import net_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    output logic               any,
    output logic [GRANT_W-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest requester is written last.
    always_comb begin
        any = |req;
        idx = '0;
        for (int off = NUM_SRC - 1; off >= 0; off--) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (req[i] && (wrap_idx(ptr, off, NUM_SRC) == GRANT_W'(i))) begin
                    idx = GRANT_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/net_tx_arbiter.sv
// Packet-granular round-robin arbiter from NUM_SRC TX streams onto one toNet stream.
// Per-source packet counters are built only when NET_TX_ARB_STATS_EN is defined.
module net_tx_arbiter
    import net_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic             apclk,
    input  logic             apreset,
    net_tx_arbiter_if.slave  bus
);

    arb_state_e         state_q, state_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic               pick_any;
    logic [GRANT_W-1:0] pick_idx;
    logic               pkt_done;

    rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req (bus.src_axis_tvalid),
        .ptr (rr_ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // NOTE: every output and next-state value gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d               = state_q;
        grant_d               = grant_q;
        rr_ptr_d              = rr_ptr_q;
        pkt_done              = 1'b0;
        bus.src_axis_tready   = '0;
        bus.toNet_axis_tdata  = '0;
        bus.toNet_axis_tkeep  = '0;
        bus.toNet_axis_tuser  = '0;
        bus.toNet_axis_tlast  = 1'b0;
        bus.toNet_axis_tvalid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = SEND;
                end
            end
            SEND: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (grant_q == GRANT_W'(i)) begin
                        bus.toNet_axis_tdata  = bus.src_axis_tdata[i*DATA_W +: DATA_W];
                        bus.toNet_axis_tkeep  = bus.src_axis_tkeep[i*KEEP_W +: KEEP_W];
                        bus.toNet_axis_tuser  = bus.src_axis_tuser[i*USER_W +: USER_W];
                        bus.toNet_axis_tlast  = bus.src_axis_tlast[i];
                        bus.toNet_axis_tvalid = bus.src_axis_tvalid[i];
                        bus.src_axis_tready[i] = bus.toNet_axis_tready;
                    end
                end
                pkt_done = bus.toNet_axis_tvalid & bus.toNet_axis_tready & bus.toNet_axis_tlast;
                if (pkt_done) begin
                    state_d  = IDLE;
                    rr_ptr_d = wrap_idx(grant_q, 1, NUM_SRC);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments only; combinational blocks above use blocking.
    always_ff @(posedge apclk or posedge apreset) begin
        if (apreset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.grant_id = grant_q;
    assign bus.busy     = (state_q == SEND);

`ifdef NET_TX_ARB_STATS_EN
    logic [NUM_SRC-1:0][CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    // Clear takes priority over a completing packet; counts stick at all-ones.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (bus.stats_clear) begin
            pkt_cnt_d = '0;
        end else if (pkt_done) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if ((grant_q == GRANT_W'(i)) && (pkt_cnt_q[i] != '1)) begin
                    pkt_cnt_d[i] = pkt_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: the counter array is a small register bank, not a RAM, so it is reset along with the FSM.
    always_ff @(posedge apclk or posedge apreset) begin
        if (apreset) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign bus.pkt_cnt = pkt_cnt_q;
`else
    logic unused_stats_clear;
    assign unused_stats_clear = bus.stats_clear;
    assign bus.pkt_cnt        = '0;
`endif

endmodule

// File: tb/tb_net_tx_arbiter.sv
// Directed self-checking bench for net_tx_arbiter (NUM_SRC=2); counter checks follow NET_TX_ARB_STATS_EN.
module tb_net_tx_arbiter;
    import net_tx_arb_pkg::*;

`ifdef NET_TX_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic apclk;
    logic apreset;
    int   vectors;
    int   miscompares;

    net_tx_arbiter_if #(.NUM_SRC(2)) bus ();

    net_tx_arbiter #(.NUM_SRC(2)) dut (
        .apclk   (apclk),
        .apreset (apreset),
        .bus     (bus.slave)
    );

    initial apclk = 1'b0;
    always #5 apclk = ~apclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] dat(input bit s, input int k);
        return {32'hD000_0000, 15'b0, s, 8'b0, 8'(k)};
    endfunction

    function automatic logic [7:0] kp(input bit s, input int k);
        return {3'b100, s, 4'(k)};
    endfunction

    function automatic logic [63:0] cnt_exp(input logic [31:0] n);
        return STATS ? 64'(n) : 64'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge apclk);
        #1;
    endtask

    task automatic drive(input bit s, input bit v, input int k, input bit l);
        bus.src_axis_tvalid[s]           = v;
        bus.src_axis_tlast[s]            = l;
        bus.src_axis_tdata[{s, 6'b0} +: 64] = dat(s, k);
        bus.src_axis_tkeep[{s, 3'b0} +: 8]  = kp(s, k);
        bus.src_axis_tuser[{s, 6'b0} +: 64] = ~dat(s, k);
    endtask

    task automatic idle_src(input bit s);
        bus.src_axis_tvalid[s] = 1'b0;
        bus.src_axis_tlast[s]  = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        #1;
        check({tag, ".busy"},   64'(bus.busy),              64'd0);
        check({tag, ".tvalid"}, 64'(bus.toNet_axis_tvalid), 64'd0);
        check({tag, ".sready"}, 64'(bus.src_axis_tready),   64'd0);
        check({tag, ".tdata"},  bus.toNet_axis_tdata,       64'd0);
    endtask

    task automatic chk_pass(input string tag, input bit s, input int k, input bit l, input bit r);
        #1;
        check({tag, ".busy"},   64'(bus.busy),              64'd1);
        check({tag, ".grant"},  64'(bus.grant_id),          64'(s));
        check({tag, ".tvalid"}, 64'(bus.toNet_axis_tvalid), 64'd1);
        check({tag, ".tdata"},  bus.toNet_axis_tdata,       dat(s, k));
        check({tag, ".tkeep"},  64'(bus.toNet_axis_tkeep),  64'(kp(s, k)));
        check({tag, ".tuser"},  bus.toNet_axis_tuser,       ~dat(s, k));
        check({tag, ".tlast"},  64'(bus.toNet_axis_tlast),  64'(l));
        check({tag, ".sready"}, 64'(bus.src_axis_tready),   s ? {62'd0, r, 1'b0} : {63'd0, r});
    endtask

    task automatic do_reset();
        apreset = 1'b1;
        #1;
        check("rst.busy",   64'(bus.busy),              64'd0);
        check("rst.tvalid", 64'(bus.toNet_axis_tvalid), 64'd0);
        check("rst.sready", 64'(bus.src_axis_tready),   64'd0);
        check("rst.grant",  64'(bus.grant_id),          64'd0);
        check("rst.cnt",    64'(bus.pkt_cnt),           64'd0);
        step();
        apreset = 1'b0;
    endtask

    initial begin
        int  k;
        bit  s;
        bit  r;
        vectors                = 0;
        miscompares            = 0;
        apreset                = 1'b1;
        bus.src_axis_tdata     = '0;
        bus.src_axis_tkeep     = '0;
        bus.src_axis_tuser     = '0;
        bus.src_axis_tlast     = '0;
        bus.src_axis_tvalid    = '0;
        bus.toNet_axis_tready  = 1'b1;
        bus.stats_clear        = 1'b0;
        repeat (2) @(posedge apclk);
        #1;
        do_reset();

        // Single source, 4-beat packet, no backpressure.
        drive(1'b0, 1'b1, 0, 1'b0);
        chk_idle("t1.arb");
        step();
        for (int b = 0; b < 4; b++) begin
            drive(1'b0, 1'b1, b, b == 3);
            chk_pass("t1.beat", 1'b0, b, b == 3, 1'b1);
            step();
        end
        idle_src(1'b0);
        chk_idle("t1.end");
        check("t1.cnt0", 64'(bus.pkt_cnt[31:0]), cnt_exp(32'd1));
        step();

        // Both sources continuously valid, 3-beat packets, from rr_ptr=0: grants 0,1,0,1.
        do_reset();
        for (int p = 0; p < 4; p++) begin
            s = p[0];
            drive(s, 1'b1, 0, 1'b0);
            drive(~s, 1'b1, 0, 1'b0);
            chk_idle("t2.gap");
            step();
            for (int b = 0; b < 3; b++) begin
                drive(s, 1'b1, b, b == 2);
                drive(~s, 1'b1, 0, 1'b0);
                chk_pass("t2.beat", s, b, b == 2, 1'b1);
                step();
            end
        end
        idle_src(1'b0);
        idle_src(1'b1);
        check("t2.cnt0", 64'(bus.pkt_cnt[31:0]),  cnt_exp(32'd2));
        check("t2.cnt1", 64'(bus.pkt_cnt[63:32]), cnt_exp(32'd2));

        // src1 5-beat packet under 1010 backpressure while src0 waits with a pending packet.
        drive(1'b1, 1'b1, 0, 1'b0);
        chk_idle("t3.arb");
        step();
        k = 0;
        for (int c = 0; c < 9; c++) begin
            r = (c % 2 == 0);
            bus.toNet_axis_tready = r;
            drive(1'b1, 1'b1, k, k == 4);
            drive(1'b0, 1'b1, 0, 1'b1);
            chk_pass("t3.beat", 1'b1, k, k == 4, r);
            step();
            if (r) k++;
        end
        bus.toNet_axis_tready = 1'b1;
        idle_src(1'b1);
        chk_idle("t3.end");
        check("t3.cnt1", 64'(bus.pkt_cnt[63:32]), cnt_exp(32'd3));
        step();

        // src0 granted next; it drops tvalid for a cycle but keeps the grant, then sends a 1-beat packet.
        drive(1'b0, 1'b0, 0, 1'b1);
        #1;
        check("t4.busy",   64'(bus.busy),              64'd1);
        check("t4.grant",  64'(bus.grant_id),          64'd0);
        check("t4.tvalid", 64'(bus.toNet_axis_tvalid), 64'd0);
        check("t4.sready", 64'(bus.src_axis_tready),   64'd1);
        step();
        drive(1'b0, 1'b1, 0, 1'b1);
        chk_pass("t4.single", 1'b0, 0, 1'b1, 1'b1);
        step();
        idle_src(1'b0);
        chk_idle("t4.end");
        check("t4.cnt0", 64'(bus.pkt_cnt[31:0]), cnt_exp(32'd3));

        // Reset during beat 2 of a 4-beat src0 packet (rr_ptr is 1 beforehand).
        drive(1'b0, 1'b1, 0, 1'b0);
        step();
        for (int b = 0; b < 2; b++) begin
            drive(1'b0, 1'b1, b, 1'b0);
            chk_pass("t5.beat", 1'b0, b, 1'b0, 1'b1);
            step();
        end
        drive(1'b0, 1'b1, 2, 1'b0);
        drive(1'b1, 1'b1, 0, 1'b1);
        do_reset();
        chk_idle("t5.after");
        step();

        // Both valid after reset: rr_ptr=0 gives src0; stats_clear coincides with its tlast.
        drive(1'b0, 1'b1, 0, 1'b1);
        bus.stats_clear = 1'b1;
        chk_pass("t6.clr", 1'b0, 0, 1'b1, 1'b1);
        step();
        bus.stats_clear = 1'b0;
        idle_src(1'b0);
        chk_idle("t6.end");
        check("t6.cnt0", 64'(bus.pkt_cnt[31:0]), 64'd0);
        step();
        chk_pass("t6.src1", 1'b1, 0, 1'b1, 1'b1);
        step();
        idle_src(1'b1);
        check("t6.cnt1", 64'(bus.pkt_cnt[63:32]), cnt_exp(32'd1));

`ifdef NET_TX_ARB_STATS_EN
        // Counter saturation from a preloaded value.
        force dut.pkt_cnt_q = {32'd1, 32'hFFFF_FFFE};
        #1;
        release dut.pkt_cnt_q;
        for (int p = 0; p < 2; p++) begin
            drive(1'b0, 1'b1, 0, 1'b1);
            chk_idle("t7.arb");
            step();
            chk_pass("t7.beat", 1'b0, 0, 1'b1, 1'b1);
            step();
            idle_src(1'b0);
            check("t7.cnt0", 64'(bus.pkt_cnt[31:0]), 64'h0000_0000_FFFF_FFFF);
        end
        check("t7.cnt1", 64'(bus.pkt_cnt[63:32]), 64'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
